// File: rtl/turtle_mem_pkg.sv
// Shared core/memory definitions: access width codes, timer register offsets, default map.
package turtle_mem_pkg;

  typedef enum logic [1:0] {
    WIDTH_BYTE    = 2'd0,
    WIDTH_HALF    = 2'd1,
    WIDTH_WORD    = 2'd2,
    WIDTH_ILLEGAL = 2'd3
  } mem_width_e;

  localparam logic [3:0] TMR_MTIME_LO    = 4'h0;
  localparam logic [3:0] TMR_MTIME_HI    = 4'h4;
  localparam logic [3:0] TMR_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] TMR_MTIMECMP_HI = 4'hC;

  localparam logic [31:0] DEFAULT_RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TIMER_BASE = 32'h0200_0000;

  // Byte lanes touched by an access of width w at byte offset lo within the word.
  function automatic logic [3:0] lane_mask(input mem_width_e w, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (w)
      WIDTH_BYTE: m = 4'b0001 << lo;
      WIDTH_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      WIDTH_WORD: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_timer.sv
// Machine timer: free-running 64-bit mtime, mtimecmp, registered irq; reads combinational.
// Writes to an mtime half load that half and skip the increment for that cycle.
module mem_timer
  import turtle_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_en,
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_wr_dat,
  output logic [31:0] o_rd_dat,
  output logic        o_irq
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_irq;
  logic [3:0]  w_off;

  assign w_off = {i_sel, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtime    <= 64'h0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= (r_mtime >= r_mtimecmp);
      if (i_wr_en && (w_off == TMR_MTIME_LO)) begin
        r_mtime[31:0] <= i_wr_dat;
      end else if (i_wr_en && (w_off == TMR_MTIME_HI)) begin
        r_mtime[63:32] <= i_wr_dat;
      end else begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (i_wr_en && (w_off == TMR_MTIMECMP_LO)) r_mtimecmp[31:0]  <= i_wr_dat;
      if (i_wr_en && (w_off == TMR_MTIMECMP_HI)) r_mtimecmp[63:32] <= i_wr_dat;
    end
  end

  always_comb begin
    o_rd_dat = 32'h0;
    case (w_off)
      TMR_MTIME_LO:    o_rd_dat = r_mtime[31:0];
      TMR_MTIME_HI:    o_rd_dat = r_mtime[63:32];
      TMR_MTIMECMP_LO: o_rd_dat = r_mtimecmp[31:0];
      TMR_MTIMECMP_HI: o_rd_dat = r_mtimecmp[63:32];
      default:         o_rd_dat = 32'h0;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/mem_responder.sv
// RAM + optional machine timer (MEM_RESPONDER_TIMER_EN) responder; read data 1 cycle after request.
// No backpressure: every access completes in one cycle; illegal ones are dropped and pulse mem_fault.
module mem_responder
  import turtle_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter logic [31:0] RAM_BASE   = DEFAULT_RAM_BASE,
  parameter logic [31:0] TIMER_BASE = DEFAULT_TIMER_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [1:0]  mem_width,
  output logic        mem_fault,
  output logic        timer_irq
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_dout;
  logic          r_fault;

  mem_width_e    w_width;
  logic [31:0]   w_ram_off;
  logic [31:0]   w_tmr_off;
  logic          w_ram_win;
  logic          w_tmr_win;
  logic          w_tmr_ok;
  logic          w_align_ok;
  logic          w_fault;
  logic          w_access;
  logic          w_ram_we;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdat;
  logic [31:0]   w_ram_shift;
  logic [31:0]   w_ram_rdat;
  logic [31:0]   w_tmr_rdat;
  logic [31:0]   w_rdat;

  assign w_width   = mem_width_e'(mem_width);
  assign w_access  = mem_read_en | mem_write_en;
  assign w_ram_off = mem_addr - RAM_BASE;
  assign w_tmr_off = mem_addr - TIMER_BASE;
  assign w_ram_win = (w_ram_off < RAM_BYTES);
  assign w_tmr_win = (w_tmr_off < 32'd16);
  assign w_idx     = w_ram_off[AW+1:2];

  always_comb begin
    w_align_ok = 1'b0;
    case (w_width)
      WIDTH_BYTE: w_align_ok = 1'b1;
      WIDTH_HALF: w_align_ok = ~mem_addr[0];
      WIDTH_WORD: w_align_ok = (mem_addr[1:0] == 2'b00);
      default:    w_align_ok = 1'b0;
    endcase
  end

  // RAM wins if a misconfigured map lets the two windows overlap.
  assign w_fault  = ~w_align_ok | ~(w_ram_win | (w_tmr_win & w_tmr_ok));
  assign w_ram_we = mem_write_en & ~w_fault & w_ram_win & ~reset;
  assign w_be     = lane_mask(w_width, mem_addr[1:0]);

  always_comb begin
    w_wdat = mem_din;
    case (w_width)
      WIDTH_BYTE: w_wdat = {4{mem_din[7:0]}};
      WIDTH_HALF: w_wdat = {2{mem_din[15:0]}};
      default:    w_wdat = mem_din;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  assign w_ram_shift = r_ram[w_idx] >> {mem_addr[1:0], 3'b000};

  always_comb begin
    w_ram_rdat = w_ram_shift;
    case (w_width)
      WIDTH_BYTE: w_ram_rdat = {24'h0, w_ram_shift[7:0]};
      WIDTH_HALF: w_ram_rdat = {16'h0, w_ram_shift[15:0]};
      default:    w_ram_rdat = w_ram_shift;
    endcase
  end

  assign w_rdat = w_ram_win ? w_ram_rdat : w_tmr_rdat;

`ifdef MEM_RESPONDER_TIMER_EN
  logic w_tmr_we;

  // Alignment already forces a word-aligned offset, so all four timer slots are legal.
  assign w_tmr_ok = (w_width == WIDTH_WORD);
  assign w_tmr_we = mem_write_en & ~w_fault & ~w_ram_win & ~reset;

  mem_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (w_tmr_we),
    .i_sel    (w_tmr_off[3:2]),
    .i_wr_dat (mem_din),
    .o_rd_dat (w_tmr_rdat),
    .o_irq    (timer_irq)
  );
`else
  assign w_tmr_ok   = 1'b0;
  assign w_tmr_rdat = 32'h0;
  assign timer_irq  = 1'b0;
`endif

  // Read data is sampled before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout  <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_access & w_fault;
      if (mem_read_en) r_dout <= w_fault ? 32'h0 : w_rdat;
    end
  end

  assign mem_dout  = r_dout;
  assign mem_fault = r_fault;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized RAM traffic against a byte-array model.
module tb_mem_responder;

  localparam logic [31:0] TB_TIMER  = 32'h0200_0000;
  localparam logic [31:0] RAM_BYTES = 32'h0000_4000;
  localparam logic [1:0]  W_B = 2'd0, W_H = 2'd1, W_W = 2'd2, W_X = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_din = 32'h0;
  logic [31:0] mem_dout;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [1:0]  mem_width = 2'd2;
  logic        mem_fault;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_mem [256];
  logic [31:0] m_dout;

  mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_width    (mem_width),
    .mem_fault    (mem_fault),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                    input logic [1:0] w);
    mem_addr = a; mem_din = d; mem_read_en = rd; mem_write_en = wr; mem_width = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(32'h0, 32'h0, 1'b0, 1'b0, W_W);
  endtask

  function automatic logic [31:0] m_read(input int o, input logic [1:0] w);
    case (w)
      W_B:     return {24'h0, m_mem[o]};
      W_H:     return {16'h0, m_mem[o+1], m_mem[o]};
      default: return {m_mem[o+3], m_mem[o+2], m_mem[o+1], m_mem[o]};
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h want=0", mem_dout); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", mem_fault); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", timer_irq); end
  endtask

  task automatic test_byte_write();
    op(32'h100, 32'h1122_3344, 1'b0, 1'b1, W_W);
    op(32'h102, 32'h0000_00AA, 1'b0, 1'b1, W_B);
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL bw_wr_fault got=%b want=0", mem_fault); end
    op(32'h100, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'h11AA_3344) begin errors++; $display("FAIL bw_read got=%h want=11aa3344", mem_dout); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL bw_rd_fault got=%b want=0", mem_fault); end
  endtask

  task automatic test_justified_reads();
    op(32'h102, 32'h0, 1'b1, 1'b0, W_H);
    checks++; if (mem_dout !== 32'h0000_11AA) begin errors++; $display("FAIL rj_half got=%h want=000011aa", mem_dout); end
    op(32'h103, 32'h0, 1'b1, 1'b0, W_B);
    checks++; if (mem_dout !== 32'h0000_0011) begin errors++; $display("FAIL rj_byte3 got=%h want=00000011", mem_dout); end
    op(32'h100, 32'h0, 1'b1, 1'b0, W_B);
    checks++; if (mem_dout !== 32'h0000_0044) begin errors++; $display("FAIL rj_byte0 got=%h want=00000044", mem_dout); end
    op(32'h100, 32'h0, 1'b1, 1'b0, W_H);
    checks++; if (mem_dout !== 32'h0000_3344) begin errors++; $display("FAIL rj_half0 got=%h want=00003344", mem_dout); end
  endtask

  task automatic test_faults();
    op(32'h101, 32'h0, 1'b1, 1'b0, W_H);
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL flt_half_dout got=%h want=0", mem_dout); end
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL flt_half_pulse got=%b want=1", mem_fault); end
    idle();
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL flt_pulse_end got=%b want=0", mem_fault); end
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL flt_idle_hold got=%h want=0", mem_dout); end
    op(32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, W_W);
    op(32'h1_0000, 32'h1234_5678, 1'b0, 1'b1, W_W);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL flt_oor_wr got=%b want=1", mem_fault); end
    op(32'h0, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'hCAFE_F00D) begin errors++; $display("FAIL flt_oor_ram got=%h want=cafef00d", mem_dout); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL flt_ok_rd got=%b want=0", mem_fault); end
    op(32'h102, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL flt_word_mis got=%b want=1", mem_fault); end
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL flt_word_mis_dout got=%h want=0", mem_dout); end
    op(32'h100, 32'h0, 1'b1, 1'b0, W_X);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL flt_width3 got=%b want=1", mem_fault); end
    op(RAM_BYTES - 32'd4, 32'hA5A5_0001, 1'b0, 1'b1, W_W);
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL flt_last_wr got=%b want=0", mem_fault); end
    op(RAM_BYTES - 32'd4, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'hA5A5_0001) begin errors++; $display("FAIL flt_last_rd got=%h want=a5a50001", mem_dout); end
    op(RAM_BYTES, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL flt_past_end got=%b want=1", mem_fault); end
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL flt_past_end_dout got=%h want=0", mem_dout); end
  endtask

  task automatic test_read_write();
    op(32'h200, 32'd5, 1'b0, 1'b1, W_W);
    op(32'h200, 32'd9, 1'b1, 1'b1, W_W);
    checks++; if (mem_dout !== 32'd5) begin errors++; $display("FAIL rw_old got=%h want=5", mem_dout); end
    op(32'h200, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'd9) begin errors++; $display("FAIL rw_new got=%h want=9", mem_dout); end
  endtask

  task automatic test_reset_mid_read();
    op(32'h100, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'h11AA_3344) begin errors++; $display("FAIL rmr_pre got=%h want=11aa3344", mem_dout); end
    mem_addr = 32'h200; mem_din = 32'hDEAD; mem_read_en = 1'b1; mem_write_en = 1'b1; mem_width = W_W;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL rmr_dout got=%h want=0", mem_dout); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rmr_fault got=%b want=0", mem_fault); end
    op(32'h101, 32'h0, 1'b1, 1'b0, W_H);
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rmr_flt_in_reset got=%b want=0", mem_fault); end
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL rmr_dout2 got=%h want=0", mem_dout); end
    reset = 1'b0;
    op(32'h200, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'd9) begin errors++; $display("FAIL rmr_wr_ignored got=%h want=9", mem_dout); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  w;
    logic        rd, wr, f;
    int          o;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      op(32'h300 + 32'(4 * i), d, 1'b0, 1'b1, W_W);
      {m_mem[4*i+3], m_mem[4*i+2], m_mem[4*i+1], m_mem[4*i]} = d;
    end
    op(32'h300, 32'h0, 1'b1, 1'b0, W_W);
    m_dout = m_read(0, W_W);
    checks++; if (mem_dout !== m_dout) begin errors++; $display("FAIL rnd_init got=%h want=%h", mem_dout, m_dout); end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) a = RAM_BYTES + 32'($urandom_range(0, 15));
      else a = 32'h300 + 32'($urandom_range(0, 255));
      w  = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      f  = (w == W_X) || (w == W_H && a[0]) || (w == W_W && a[1:0] != 2'b00) || (a >= RAM_BYTES);
      o  = int'(a) - 32'h300;
      if (rd) m_dout = f ? 32'h0 : m_read(o, w);
      if (wr && !f) begin
        m_mem[o] = d[7:0];
        if (w != W_B) m_mem[o+1] = d[15:8];
        if (w == W_W) begin m_mem[o+2] = d[23:16]; m_mem[o+3] = d[31:24]; end
      end
      op(a, d, rd, wr, w);
      checks++;
      if (mem_fault !== ((rd | wr) & f)) begin
        errors++; $display("FAIL rnd_fault n=%0d a=%h w=%0d got=%b want=%b", n, a, w, mem_fault, (rd | wr) & f);
      end
      checks++;
      if (mem_dout !== m_dout) begin
        errors++; $display("FAIL rnd_dout n=%0d a=%h w=%0d got=%h want=%h", n, a, w, mem_dout, m_dout);
      end
    end
  endtask

`ifdef MEM_RESPONDER_TIMER_EN
  task automatic test_timer();
    // mtime counts edges since reset release: after edge n it holds n.
    reset = 1'b1;
    idle();
    reset = 1'b0;
    op(TB_TIMER + 32'hC, 32'd0, 1'b0, 1'b1, W_W);
    op(TB_TIMER + 32'h8, 32'd20, 1'b0, 1'b1, W_W);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_irq_e2 got=%b want=0", timer_irq); end
    for (int n = 3; n <= 25; n++) begin
      idle();
      checks++;
      if (timer_irq !== (n >= 21)) begin
        errors++; $display("FAIL tmr_irq edge=%0d got=%b want=%b", n, timer_irq, n >= 21);
      end
    end
    op(TB_TIMER, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'd25) begin errors++; $display("FAIL tmr_mtime_lo got=%0d want=25", mem_dout); end
    op(TB_TIMER + 32'hC, 32'd1, 1'b0, 1'b1, W_W);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL tmr_cmp_lag got=%b want=1", timer_irq); end
    idle();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_cmp_new got=%b want=0", timer_irq); end
    op(TB_TIMER, 32'hFFFF_FFFF, 1'b0, 1'b1, W_W);
    op(TB_TIMER + 32'h4, 32'h0, 1'b0, 1'b1, W_W);
    op(TB_TIMER + 32'h4, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'd0) begin errors++; $display("FAIL tmr_hi_pre got=%h want=0", mem_dout); end
    op(TB_TIMER + 32'h4, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'd1) begin errors++; $display("FAIL tmr_hi_carry got=%h want=1", mem_dout); end
    op(TB_TIMER, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'd1) begin errors++; $display("FAIL tmr_lo_after got=%h want=1", mem_dout); end
    op(TB_TIMER + 32'h8, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_dout !== 32'd20) begin errors++; $display("FAIL tmr_cmp_rd got=%h want=20", mem_dout); end
    op(TB_TIMER, 32'h0, 1'b1, 1'b0, W_H);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL tmr_half got=%b want=1", mem_fault); end
    op(TB_TIMER + 32'h10, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL tmr_bad_off got=%b want=1", mem_fault); end
  endtask
`else
  task automatic test_no_timer();
    op(TB_TIMER, 32'h0, 1'b1, 1'b0, W_W);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL notmr_rd_fault got=%b want=1", mem_fault); end
    checks++; if (mem_dout !== 32'h0) begin errors++; $display("FAIL notmr_rd_dout got=%h want=0", mem_dout); end
    op(TB_TIMER + 32'h8, 32'h0, 1'b0, 1'b1, W_W);
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL notmr_wr_fault got=%b want=1", mem_fault); end
    for (int n = 0; n < 5; n++) begin
      idle();
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL notmr_irq n=%0d got=%b want=0", n, timer_irq); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_byte_write();
    test_justified_reads();
    test_faults();
    test_read_write();
    test_reset_mid_read();
    test_random();
`ifdef MEM_RESPONDER_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, giving the number of 32-bit RAM words (16 KiB).
REQ-002 SHALL have parameter RAM_BASE, default 32'h0000_0000, giving the RAM base byte address.
REQ-003 SHALL have parameter TIMER_BASE, default 32'h0200_0000, giving the timer register block base byte address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port mem_addr, input, 32 bits: byte address from the core.
REQ-007 SHALL have port mem_din, input, 32 bits: write data from the core; the valid bytes are right-justified.
REQ-008 SHALL have port mem_dout, output, 32 bits: read data to the core.
REQ-009 SHALL have port mem_read_en, input, 1 bit: read request this cycle.
REQ-010 SHALL have port mem_write_en, input, 1 bit: write request this cycle.
REQ-011 SHALL have port mem_width, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-012 SHALL have port mem_fault, output, 1 bit: one-cycle pulse flagging a rejected access.
REQ-013 SHALL have port timer_irq, output, 1 bit: machine timer interrupt request, level.

Function
REQ-014 SHALL present read data on mem_dout in the cycle after mem_read_en is sampled high (1-cycle latency), and SHALL hold it until the next accepted read or reset.
REQ-015 SHALL right-justify byte and half reads, shifting the RAM word right by 8*mem_addr[1:0] bits and zero-filling the upper bits; sign extension belongs to the core.
REQ-016 SHALL write byte accesses to lane mem_addr[1:0] using mem_din[7:0].
REQ-017 SHALL write half accesses to lanes {mem_addr[1],0}+1:0 using mem_din[15:0].
REQ-018 SHALL write word accesses to all four lanes.
REQ-019 SHALL fault an access that meets any of: half with mem_addr[0]=1; word with mem_addr[1:0]!=0; mem_width=3; address outside both the RAM and timer windows.
REQ-020 SHALL, on a faulted access, drop the write, return 32'h0 for a read, and pulse mem_fault high for exactly one cycle, aligned with the data cycle.
REQ-021 SHALL, when mem_read_en and mem_write_en are both high for the same address, perform the write and return the pre-write data (read-before-write).
REQ-022 SHALL treat a cycle with neither enable high as idle: no state change except the timer, and mem_dout held.
REQ-023 SHALL map timer registers at TIMER_BASE offsets: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
REQ-024 SHALL fault any non-word timer access and any timer offset other than those in REQ-023.
REQ-025 SHALL increment mtime by 1 every cycle, wrapping from all-ones to 0.
REQ-026 SHALL, when software writes an mtime half, load the written value and suppress the increment for that cycle.
REQ-027 SHALL drive timer_irq as a registered copy of (mtime >= mtimecmp), compared unsigned over 64 bits, so it lags the compare by one cycle.
REQ-028 SHALL, after a write to mtimecmp, reflect the new compare result on timer_irq on the second edge after the write.

Reset
REQ-029 SHALL, on reset, set mem_dout=0, mem_fault=0, timer_irq=0, mtime=0 and mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
REQ-030 SHALL discard a read pending across reset; its data SHALL never appear on mem_dout.
REQ-031 SHALL leave RAM contents unreset and ignore writes presented in a reset cycle.

Configuration
REQ-032 SHALL, with MEM_RESPONDER_TIMER_EN defined, include the timer per REQ-023 to REQ-028.
REQ-033 SHALL, without MEM_RESPONDER_TIMER_EN, treat the timer window as out of range (access faults per REQ-019), tie timer_irq to 0, and instantiate no timer state.

Structure
REQ-034 SHALL take the width encodings (WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD), the timer offset constants and the default base addresses from shared package turtle_mem_pkg, which the core also uses.
REQ-035 SHALL implement the timer as sub-module mem_timer (mtime, mtimecmp, register write/read port, timer_irq), instantiated only under MEM_RESPONDER_TIMER_EN.

Verification
REQ-036 SHALL cover byte writes: write word 0x11223344 to 0x100, write byte 0xAA to 0x102, read word at 0x100 -> 0x11AA3344 one cycle later, mem_fault=0.
REQ-037 SHALL cover right-justified reads: with RAM[0x100]=0x11AA3344, read half at 0x102 -> 0x000011AA; read byte at 0x103 -> 0x00000011.
REQ-038 SHALL cover faults: half read at 0x101 -> mem_dout=0 with a one-cycle mem_fault pulse; word write at 0x1_0000 (out of range) -> RAM unchanged and mem_fault pulse.
REQ-039 SHALL cover simultaneous read/write: RAM[0x200]=5, then read+write 9 at 0x200 in the same cycle -> mem_dout=5, and a subsequent read -> 9.
REQ-040 SHALL cover the timer: write mtimecmp hi=0, lo=20 after reset -> timer_irq rises on the cycle after mtime reaches 20; write mtime lo=0xFFFF_FFFF, hi=0 -> read mtime hi shows 1 after the carry.
REQ-041 SHALL cover reset mid-read: read issued with reset asserted on the next edge -> mem_dout=0 and no fault; with MEM_RESPONDER_TIMER_EN undefined, a read at TIMER_BASE -> fault and timer_irq stays 0.
